// File: rtl/push_event_fsm_pkg.sv
// -----------------------------------------------------------------------------
// push_event_fsm_pkg
// Shared definitions for the push-button front-end: the default press-duration
// counter width, the FSM state encoding and a counter-width helper.
// Optional feature macro used by the design: PUSH_AUTOREPEAT_EN.
// -----------------------------------------------------------------------------
package push_event_fsm_pkg;

   // Default width of the press-duration counter and of o_press_len.
   localparam int unsigned CNT_LEN_DEF = 16;

   // Width of the state encoding.
   localparam int unsigned ST_W = 3;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_PRESS  = 3'd1,
      ST_HELD   = 3'd2,
      ST_GAP    = 3'd3,
      ST_SECOND = 3'd4
   } state_e;

   // Bits needed to hold values 0..max_val (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned max_val);
      int unsigned w;
      w = $clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/push_debounce.sv
// -----------------------------------------------------------------------------
// push_debounce
// Two-flop synchroniser on the raw active-low button pin followed by a
// stability counter. The debounced level only changes after the synchronised
// pin has differed from it for DEB_CYC consecutive cycles, so the
// pin-to-output latency is DEB_CYC+2 cycles.
//
// Ports:
//   i_clk     system clock, rising edge
//   i_rst     synchronous active-high reset
//   i_push_n  raw button pin, 0 = pressed, asynchronous to i_clk
//   o_deb_n   debounced level, 0 = pressed
// -----------------------------------------------------------------------------
module push_debounce
   import push_event_fsm_pkg::*;
#(
   parameter int unsigned DEB_CYC = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_push_n,
   output logic o_deb_n
);

   localparam int unsigned DW = cnt_width(DEB_CYC - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          deb_q;
   logic          deb_d;
   logic [DW-1:0] cnt_q;
   logic [DW-1:0] cnt_d;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         deb_q   <= 1'b1;
         cnt_q   <= '0;
      end else begin
         sync1_q <= i_push_n;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
      end
   end

   // Any cycle where the synchronised pin agrees with the output restarts
   // the stability count, so short glitches never reach the output.
   always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (sync2_q != deb_q) begin
         if (cnt_q == DW'(DEB_CYC - 1)) begin
            deb_d = ~deb_q;
         end else begin
            cnt_d = cnt_q + DW'(1);
         end
      end
   end

   assign o_deb_n = deb_q;

endmodule

// File: rtl/push_event_fsm.sv
// -----------------------------------------------------------------------------
// push_event_fsm
// Board push-button front-end: debounces the raw pin, measures each press and
// classifies it as short, long or double-click, each class producing a
// single-cycle event pulse.
//
// Optional feature macro: PUSH_AUTOREPEAT_EN
//   defined   - o_long re-pulses every REP_CYC cycles while the button is held
//   undefined - o_long fires once per press; no repeat counter exists
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        synchronous active-high reset
//   i_push_n     raw button pin, 0 = pressed
//   o_deb_n      debounced level, 0 = pressed
//   o_short      one-cycle pulse: single short press confirmed
//   o_long       one-cycle pulse: hold reached LONG_CYC
//   o_double     one-cycle pulse: second press started within DBL_CYC
//   o_press_len  duration of the last completed press in cycles, saturating
//   o_busy       high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module push_event_fsm
   import push_event_fsm_pkg::*;
#(
   parameter int unsigned CNT_LEN  = CNT_LEN_DEF,
   parameter int unsigned DEB_CYC  = 16,
   parameter int unsigned LONG_CYC = 24000,
   parameter int unsigned DBL_CYC  = 8000,
   parameter int unsigned REP_CYC  = 4000
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_push_n,
   output logic               o_deb_n,
   output logic               o_short,
   output logic               o_long,
   output logic               o_double,
   output logic [CNT_LEN-1:0] o_press_len,
   output logic               o_busy
);

   localparam int unsigned GW = cnt_width(DBL_CYC - 1);

   if (DEB_CYC < 1 || LONG_CYC < 1 || DBL_CYC < 1 || REP_CYC < 1) begin : g_bad_param
      $error("push_event_fsm: all cycle parameters must be at least 1");
   end

   logic               deb_n;
   logic               deb_prev_q;
   logic               press;
   logic               rel;

   state_e             state_q;
   state_e             state_d;
   logic               busy_q;
   logic [CNT_LEN-1:0] hold_cnt_q;
   logic [CNT_LEN-1:0] hold_cnt_d;
   logic [CNT_LEN-1:0] hold_inc;
   logic [CNT_LEN-1:0] press_len_q;
   logic [CNT_LEN-1:0] press_len_d;
   logic [GW-1:0]      gap_cnt_q;
   logic [GW-1:0]      gap_cnt_d;

   logic               short_p;
   logic               long_p;
   logic               double_p;

   push_debounce #(
      .DEB_CYC (DEB_CYC)
   ) u_debounce (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_push_n (i_push_n),
      .o_deb_n  (deb_n)
   );

   // Press / release are the edges of the debounced level.
   assign press = deb_prev_q & ~deb_n;
   assign rel   = ~deb_prev_q & deb_n;

   // Saturating increment: the counter sticks at all-ones instead of wrapping,
   // and the latched press length reuses the same value.
   assign hold_inc = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + CNT_LEN'(1);

`ifdef PUSH_AUTOREPEAT_EN
   localparam int unsigned RW = cnt_width(REP_CYC - 1);

   logic [RW-1:0] rep_cnt_q;
   logic [RW-1:0] rep_cnt_d;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rep_cnt_q <= '0;
      end else begin
         rep_cnt_q <= rep_cnt_d;
      end
   end

   always_comb begin
      rep_cnt_d = rep_cnt_q;
      if (state_q == ST_PRESS) begin
         rep_cnt_d = '0;
      end else if (state_q == ST_HELD && !rel) begin
         rep_cnt_d = (rep_cnt_q == RW'(REP_CYC - 1)) ? '0 : rep_cnt_q + RW'(1);
      end
   end
`endif

   // State register with the counters and registered busy flag.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         busy_q      <= 1'b0;
         deb_prev_q  <= 1'b1;
         hold_cnt_q  <= '0;
         gap_cnt_q   <= '0;
         press_len_q <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= (state_d != ST_IDLE);
         deb_prev_q  <= deb_n;
         hold_cnt_q  <= hold_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         press_len_q <= press_len_d;
      end
   end

   // Next-state logic. A release seen on the same cycle the long threshold
   // is reached takes priority, so that press is treated as short.
   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      press_len_d = press_len_q;
      case (state_q)
         ST_IDLE: begin
            if (press) begin
               state_d    = ST_PRESS;
               hold_cnt_d = '0;
            end
         end
         ST_PRESS: begin
            if (rel) begin
               state_d     = ST_GAP;
               gap_cnt_d   = '0;
               press_len_d = hold_inc;
            end else begin
               hold_cnt_d = hold_inc;
               if (hold_cnt_q == CNT_LEN'(LONG_CYC - 1)) begin
                  state_d = ST_HELD;
               end
            end
         end
         ST_HELD, ST_SECOND: begin
            if (rel) begin
               state_d     = ST_IDLE;
               press_len_d = hold_inc;
            end else begin
               hold_cnt_d = hold_inc;
            end
         end
         ST_GAP: begin
            // A press on the expiry cycle still counts as a double-click.
            if (press) begin
               state_d    = ST_SECOND;
               hold_cnt_d = '0;
            end else if (gap_cnt_q == GW'(DBL_CYC - 1)) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Event pulses are decoded from the current state and this cycle's
   // conditions; they are held low while reset is asserted so that a press
   // interrupted by reset never emits an event.
   always_comb begin
      short_p  = 1'b0;
      long_p   = 1'b0;
      double_p = 1'b0;
      if (!i_rst) begin
         case (state_q)
            ST_PRESS: begin
               long_p = !rel && (hold_cnt_q == CNT_LEN'(LONG_CYC - 1));
            end
`ifdef PUSH_AUTOREPEAT_EN
            ST_HELD: begin
               long_p = !rel && (rep_cnt_q == RW'(REP_CYC - 1));
            end
`endif
            ST_GAP: begin
               double_p = press;
               short_p  = !press && (gap_cnt_q == GW'(DBL_CYC - 1));
            end
            default: begin
               short_p = 1'b0;
            end
         endcase
      end
   end

   assign o_deb_n     = deb_n;
   assign o_short     = short_p;
   assign o_long      = long_p;
   assign o_double    = double_p;
   assign o_press_len = press_len_q;
   assign o_busy      = busy_q;

endmodule
